// File: rtl/prism_sched_pkg.sv
// rtl/prism_sched_pkg.sv - shared types and constants for the PRISM reload scheduler
// Contents: state_t (sequencer states), reload_entry_t ({addr,data} queue word),
//           default widths and the reset down-counter width.
package prism_sched_pkg;

  localparam int PKG_AW    = 6;
  localparam int PKG_DW    = 32;
  // Wide enough for any practical RST_CYCLES value (up to 256).
  localparam int RST_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    QUIESCE,
    RESET,
    LOAD,
    RELEASE,
    RESUME
  } state_t;

  typedef struct packed {
    logic [PKG_AW-1:0] addr;
    logic [PKG_DW-1:0] data;
  } reload_entry_t;

endpackage

// File: rtl/prism_reload_sched_if.sv
// rtl/prism_reload_sched_if.sv - host debug write bus with ready handshake
// Signals: addr/wdata/wr driven by the host, ready returned by the scheduler.
// Modports: master = host side, slave = scheduler side.
interface prism_reload_sched_if
  import prism_sched_pkg::*;
#(
  parameter int AW = PKG_AW,
  parameter int DW = PKG_DW
) ();

  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          wr;
  logic          ready;

  modport master (output addr, output wdata, output wr, input ready);
  modport slave  (input addr, input wdata, input wr, output ready);

endinterface

// File: rtl/prism_reload_fifo.sv
// rtl/prism_reload_fifo.sv - DEPTH-entry FIFO of reload_entry_t words
// Ports: clk, rst (sync, active-high), push/wdata (write, ignored when full),
//        pop (ignored when empty), head (oldest entry), full, empty, count (0..DEPTH).
module prism_reload_fifo
  import prism_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  reload_entry_t            wdata,
  input  logic                     pop,
  output reload_entry_t            head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  reload_entry_t mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/prism_reload_sched.sv
// rtl/prism_reload_sched.sv - owns the PRISM debug port; passes host writes through or hot-reloads
// Ports: clk, rst (sync, active-high); host (slave bus: addr/wdata/wr/ready);
//        host_enable; queue push q_push/q_addr/q_data, q_count, sticky q_err, clr_err;
//        triggers start, auto_reload+prism_halt; status busy, done;
//        prism_addr/wdata/wr/enable/reset towards the prism instance.
module prism_reload_sched
  import prism_sched_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int AW         = PKG_AW,
  parameter int DW         = PKG_DW,
  parameter int RST_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  prism_reload_sched_if.slave    host,
  input  logic                   host_enable,
  input  logic                   q_push,
  input  logic [AW-1:0]          q_addr,
  input  logic [DW-1:0]          q_data,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   q_err,
  input  logic                   clr_err,
  input  logic                   start,
  input  logic                   auto_reload,
  input  logic                   prism_halt,
  output logic                   busy,
  output logic                   done,
  output logic [AW-1:0]          prism_addr,
  output logic [DW-1:0]          prism_wdata,
  output logic                   prism_wr,
  output logic                   prism_enable,
  output logic                   prism_reset
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t                 state;
  state_t                 state_nx;
  logic                   halt_q;
  logic                   pend;
  logic                   en_q;
  logic [RST_CNT_W-1:0]   rst_cnt;
  logic                   trigger;
  logic                   q_reject;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   do_pop;
  reload_entry_t          push_entry;
  reload_entry_t          head;

  assign trigger    = start | (auto_reload & prism_halt & ~halt_q);
  assign q_reject   = q_push & (fifo_full | busy);
  assign do_pop     = (state == LOAD) & ~fifo_empty;
  assign push_entry = '{addr: q_addr, data: q_data};

  prism_reload_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push & ~busy),
    .wdata (push_entry),
    .pop   (do_pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (q_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // pend is only armed from IDLE, so triggers during a reload are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q  <= 1'b0;
      en_q    <= 1'b0;
      pend    <= 1'b0;
      q_err   <= 1'b0;
      rst_cnt <= '0;
    end else begin
      halt_q <= prism_halt;
      en_q   <= host_enable;
      if (state == RESUME)                pend <= 1'b0;
      else if (state == IDLE && trigger)  pend <= 1'b1;
      if (q_reject)     q_err <= 1'b1;
      else if (clr_err) q_err <= 1'b0;
      if (state == QUIESCE)                    rst_cnt <= RST_CNT_W'(RST_CYCLES - 1);
      else if (state == RESET && rst_cnt != '0) rst_cnt <= rst_cnt - RST_CNT_W'(1);
    end
  end

  // LOAD is skipped entirely for an empty queue and left right after the last pop,
  // so the reload spans exactly 3 + RST_CYCLES + N cycles.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pend) state_nx = QUIESCE;
      QUIESCE: state_nx = RESET;
      RESET:   if (rst_cnt == '0) state_nx = fifo_empty ? RELEASE : LOAD;
      LOAD:    if (q_count <= CW'(1)) state_nx = RELEASE;
      RELEASE: state_nx = RESUME;
      RESUME:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    host.ready   = 1'b0;
    prism_addr   = head.addr;
    prism_wdata  = head.data;
    prism_wr     = 1'b0;
    prism_enable = 1'b0;
    prism_reset  = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    unique case (state)
      IDLE: begin
        host.ready   = 1'b1;
        prism_addr   = host.addr;
        prism_wdata  = host.wdata;
        prism_wr     = host.wr;
        prism_enable = en_q;
        busy         = 1'b0;
      end
      RESET: prism_reset = 1'b1;
      LOAD: begin
        prism_reset = 1'b1;
        // A reset arriving mid-load suppresses the write in that very cycle.
        prism_wr    = ~fifo_empty & ~rst;
      end
      RESUME: begin
        done         = 1'b1;
        prism_enable = en_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prism_reload_sched.sv
// tb/tb_prism_reload_sched.sv - self-checking bench for prism_reload_sched
module tb_prism_reload_sched;
  import prism_sched_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int RC    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prism_reload_sched_if #(.AW(AW), .DW(DW)) host ();

  logic          host_enable, q_push, clr_err, start, auto_reload, prism_halt;
  logic [AW-1:0] q_addr;
  logic [DW-1:0] q_data;
  logic [3:0]    q_count;
  logic          q_err, busy, done, prism_wr, prism_enable, prism_reset;
  logic [AW-1:0] prism_addr;
  logic [DW-1:0] prism_wdata;

  prism_reload_sched #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .RST_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .host(host), .host_enable(host_enable),
    .q_push(q_push), .q_addr(q_addr), .q_data(q_data), .q_count(q_count),
    .q_err(q_err), .clr_err(clr_err), .start(start), .auto_reload(auto_reload),
    .prism_halt(prism_halt), .busy(busy), .done(done), .prism_addr(prism_addr),
    .prism_wdata(prism_wdata), .prism_wr(prism_wr), .prism_enable(prism_enable),
    .prism_reset(prism_reset)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    host.wr = 0; host.addr = '0; host.wdata = '0; host_enable = 0;
    q_push = 0; q_addr = '0; q_data = '0; clr_err = 0; start = 0;
    auto_reload = 0; prism_halt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); idle_inputs(); rst = 1;
    @(negedge clk); rst = 0;
  endtask

  logic [AW-1:0] ea [3] = '{6'h08, 6'h0C, 6'h10};
  logic [DW-1:0] ed [3] = '{32'h11, 32'h22, 32'h33};

  // Pushes the three reference entries, raises host_enable, then asserts start
  // and returns at the negedge of the trigger cycle.
  task automatic load3_start();
    host_enable = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); q_push = 1; q_addr = ea[i]; q_data = ed[i];
    end
    @(negedge clk); q_push = 0; start = 1;
  endtask

  // ---- observation counters for multi-cycle sequences ----
  int m_busy, m_rst, m_done, m_first_rst, m_first_wr, m_en_bad, m_wr_any;
  reload_entry_t m_log[$];

  task automatic clr_mon();
    m_busy = 0; m_rst = 0; m_done = 0; m_first_rst = -1; m_first_wr = -1;
    m_en_bad = 0; m_wr_any = 0; m_log.delete();
  endtask

  task automatic sample(input int i);
    reload_entry_t e;
    if (busy) m_busy++;
    if (busy && !done && prism_enable) m_en_bad++;
    if (prism_reset) begin m_rst++; if (m_first_rst < 0) m_first_rst = i; end
    if (prism_wr) m_wr_any++;
    if (prism_wr && busy) begin
      if (m_first_wr < 0) m_first_wr = i;
      e.addr = prism_addr; e.data = prism_wdata;
      m_log.push_back(e);
    end
    if (done) m_done++;
  endtask

  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      #1; sample(i);
      @(negedge clk); start = 0;
    end
  endtask

  // Waits (bounded) until the first LOAD write is visible; returns 1 on success.
  task automatic wait_load(output bit found);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); start = 0; #1;
      if (prism_wr && busy) found = 1;
    end
  endtask

  // ---- table vectors: passthrough, fill/overflow, sticky error ----
  typedef struct {
    logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; logic push; logic clr;
    logic exp_wr; logic exp_ready; logic [3:0] exp_cnt; logic exp_err;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mkv(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic push, input logic clr, input logic ewr,
                               input logic erdy, input logic [3:0] ecnt, input logic eerr);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.push = push; v.clr = clr;
    v.exp_wr = ewr; v.exp_ready = erdy; v.exp_cnt = ecnt; v.exp_err = eerr;
    return v;
  endfunction

  // ---- reference model state for the random phase ----
  reload_entry_t mq[$];
  int  mk, mn;
  bit  mpend, merr, mhq, men;

  initial begin
    bit found, saw_nr, prev_done;
    rst = 1; idle_inputs();
    repeat (2) @(negedge clk);
    rst = 0; #1;
    check("reset_ready", host.ready, 1);
    check("reset_qcount", q_count, 0);
    check("reset_qerr", q_err, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_wr", prism_wr, 0);
    check("reset_enable", prism_enable, 0);
    check("reset_preset", prism_reset, 0);

    // Table
    vt.push_back(mkv(1, 6'h04, 32'hDEADBEEF, 0, 0, 1, 1, 0, 0));
    for (int i = 0; i < 9; i++)
      vt.push_back(mkv(0, AW'(i), DW'(i * 3 + 1), 1, 0, 0, 1, 4'((i < 8) ? i : 8), 0));
    vt.push_back(mkv(0, 0, 0, 0, 1, 0, 1, 8, 1));
    vt.push_back(mkv(0, 0, 0, 1, 1, 0, 1, 8, 0));
    vt.push_back(mkv(0, 0, 0, 0, 1, 0, 1, 8, 1));
    vt.push_back(mkv(0, 0, 0, 0, 0, 0, 1, 8, 0));
    foreach (vt[i]) begin
      @(negedge clk);
      host.wr = vt[i].wr; host.addr = vt[i].addr; host.wdata = vt[i].data;
      q_push = vt[i].push; q_addr = vt[i].addr; q_data = vt[i].data; clr_err = vt[i].clr;
      #1;
      check($sformatf("tbl%0d_wr", i), prism_wr, vt[i].exp_wr);
      check($sformatf("tbl%0d_ready", i), host.ready, vt[i].exp_ready);
      check($sformatf("tbl%0d_qcount", i), q_count, vt[i].exp_cnt);
      check($sformatf("tbl%0d_qerr", i), q_err, vt[i].exp_err);
      if (vt[i].exp_wr) begin
        check($sformatf("tbl%0d_addr", i), prism_addr, vt[i].addr);
        check($sformatf("tbl%0d_data", i), prism_wdata, vt[i].data);
      end
    end

    // Reload of three entries
    do_reset();
    load3_start();
    clr_mon();
    watch(14);
    #1;
    check("reload_busy_cycles", m_busy, 8);
    check("reload_reset_cycles", m_rst, 5);
    check("reload_reset_to_wr", m_first_wr - m_first_rst, RC);
    check("reload_done_pulses", m_done, 1);
    check("reload_enable_low", m_en_bad, 0);
    check("reload_nwr", m_log.size(), 3);
    for (int i = 0; i < 3 && i < m_log.size(); i++) begin
      check($sformatf("reload_addr%0d", i), m_log[i].addr, ea[i]);
      check($sformatf("reload_data%0d", i), m_log[i].data, ed[i]);
    end
    check("reload_enable_after", prism_enable, 1);
    check("reload_qcount_after", q_count, 0);

    // Auto trigger on halt rising edge, then with auto_reload off
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      auto_reload = (pass == 0);
      clr_mon();
      watch(2);
      prism_halt = 1; watch(5);
      prism_halt = 0; watch(15);
      check($sformatf("auto%0d_done", pass), m_done, (pass == 0) ? 1 : 0);
      check($sformatf("auto%0d_busy", pass), m_busy, (pass == 0) ? 3 + RC : 0);
    end

    // Host contention during LOAD, start while busy ignored
    do_reset();
    load3_start();
    wait_load(found);
    check("contend_reached_load", found, 1);
    host.wr = 1; host.addr = 6'h2A; host.wdata = 32'h5555AAAA; start = 1;
    saw_nr = 0; prev_done = 0; found = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (host.ready) begin found = 1; break; end
      saw_nr = 1; prev_done = done;
      @(negedge clk); start = 0;
    end
    check("contend_ready_seen", found, 1);
    check("contend_stalled", saw_nr, 1);
    check("contend_after_resume", prev_done, 1);
    check("contend_busy", busy, 0);
    check("contend_wr", prism_wr, 1);
    check("contend_addr", prism_addr, 6'h2A);
    check("contend_data", prism_wdata, 32'h5555AAAA);
    @(negedge clk); host.wr = 0; start = 0;
    clr_mon();
    watch(10);
    check("contend_no_rerun", m_done, 0);

    // Abort by reset mid-LOAD
    do_reset();
    load3_start();
    wait_load(found);
    check("abort_reached_load", found, 1);
    @(negedge clk); rst = 1; #1;
    check("abort_wr_gated", prism_wr, 0);
    @(negedge clk); rst = 0; #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_wr", prism_wr, 0);
    check("abort_enable", prism_enable, 0);
    check("abort_preset", prism_reset, 0);
    check("abort_ready", host.ready, 1);
    check("abort_qcount", q_count, 0);
    check("abort_qerr", q_err, 0);
    clr_mon();
    watch(10);
    check("abort_no_more_wr", m_wr_any, 0);

    // Random stimulus against the reference model
    do_reset();
    mq.delete(); mk = -1; mn = 0; mpend = 0; merr = 0; mhq = 0; men = 0;
    for (int c = 0; c < 4000; c++) begin
      bit e_ready, e_busy, e_done, e_wr, e_en, e_rst, trig, rej, load;
      logic [AW-1:0] e_addr; logic [DW-1:0] e_data;
      reload_entry_t ent;
      @(negedge clk);
      host.wr = ($urandom_range(0, 1) == 1);
      host.addr = AW'($urandom); host.wdata = $urandom;
      if ($urandom_range(0, 7) == 0) host_enable = ~host_enable;
      q_push = ($urandom_range(0, 2) == 0);
      q_addr = AW'($urandom); q_data = $urandom;
      clr_err = ($urandom_range(0, 19) == 0);
      start = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 49) == 0) auto_reload = ~auto_reload;
      if ($urandom_range(0, 5) == 0) prism_halt = ~prism_halt;
      #1;
      // Expected outputs from the offset k into the current reload.
      e_addr = host.addr; e_data = host.wdata;
      if (mk < 0) begin
        e_ready = 1; e_busy = 0; e_done = 0; e_wr = host.wr; e_en = men; e_rst = 0; load = 0;
      end else begin
        e_ready = 0; e_busy = 1;
        e_done = (mk == RC + mn + 2);
        e_en = e_done ? men : 1'b0;
        e_rst = (mk >= 1 && mk <= RC + mn);
        load = (mk > RC && mk <= RC + mn);
        e_wr = load;
        if (load) begin e_addr = mq[0].addr; e_data = mq[0].data; end
      end
      check("rnd_ready", host.ready, e_ready);
      check("rnd_busy", busy, e_busy);
      check("rnd_done", done, e_done);
      check("rnd_wr", prism_wr, e_wr);
      check("rnd_enable", prism_enable, e_en);
      check("rnd_preset", prism_reset, e_rst);
      check("rnd_qcount", q_count, mq.size());
      check("rnd_qerr", q_err, merr);
      if (e_wr) begin
        check("rnd_addr", prism_addr, e_addr);
        check("rnd_data", prism_wdata, e_data);
      end
      // Advance the model by one clock.
      trig = start | (auto_reload & prism_halt & ~mhq);
      rej = q_push && (mk >= 0 || mq.size() == DEPTH);
      if (rej) merr = 1; else if (clr_err) merr = 0;
      if (q_push && !rej) begin ent.addr = q_addr; ent.data = q_data; mq.push_back(ent); end
      if (load) void'(mq.pop_front());
      if (mk < 0) begin
        if (mpend) begin mk = 0; mn = mq.size(); end
        else if (trig) mpend = 1;
      end else if (mk == RC + mn + 2) begin
        mk = -1; mpend = 0;
      end else mk++;
      mhq = prism_halt; men = host_enable;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
